// File: rtl/user_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : user_wb_arbiter
// Brief    : Two-master round-robin Wishbone arbiter onto one shared slave.
//            Optional ack watchdog enabled by macro USER_WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module user_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

  state_t r_state;
  logic   r_last_grant;

  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_cyc;
  logic   w_stb;
  logic   w_timeout;

  assign w_gnt0 = (r_state == ST_GNT0);
  assign w_gnt1 = (r_state == ST_GNT1);

  // Request of whichever master currently owns the bus (0 in IDLE)
  assign w_cyc = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
  assign w_stb = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);

`ifdef USER_WB_ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  assign w_timeout = (w_gnt0 | w_gnt1) && (r_tmo_cnt == c_timeout);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_cyc && !w_timeout && !s_ack_i) begin
      if (w_stb) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end else begin
      r_tmo_cnt <= 8'd0;
    end
  end

  assign m0_err_o = w_gnt0 & w_timeout;
  assign m1_err_o = w_gnt1 & w_timeout;
`else
  // No watchdog: TIMEOUT_CYCLES lies in 1..255, so this folds to constant 0
  assign w_timeout = (c_timeout == 8'd0);
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_last_grant ? ST_GNT0 : ST_GNT1;
          end else if (m0_cyc_i) begin
            r_state <= ST_GNT0;
          end else if (m1_cyc_i) begin
            r_state <= ST_GNT1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i || w_timeout) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i || w_timeout) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave side mirrors the granted master; a watchdog expiry kills cyc/stb
  assign s_cyc_o = w_cyc & ~w_timeout;
  assign s_stb_o = w_stb & ~w_timeout;
  assign s_we_o  = (w_gnt0 & m0_we_i) | (w_gnt1 & m1_we_i);
  assign s_sel_o = w_gnt0 ? m0_sel_i : (w_gnt1 ? m1_sel_i : 4'h0);
  assign s_adr_o = w_gnt0 ? m0_adr_i : (w_gnt1 ? m1_adr_i : 32'h0);
  assign s_dat_o = w_gnt0 ? m0_dat_i : (w_gnt1 ? m1_dat_i : 32'h0);

  assign m0_ack_o = w_gnt0 & s_ack_i;
  assign m1_ack_o = w_gnt1 & s_ack_i;
  assign m0_dat_o = w_gnt0 ? s_dat_i : 32'h0;
  assign m1_dat_o = w_gnt1 ? s_dat_i : 32'h0;

endmodule
`default_nettype wire
